// File: rtl/async_fifo_wptr_ctrl.sv
// async_fifo_wptr_ctrl
//   Write-side pointer controller for the async FIFO, clk_tx domain.
//   Keeps an (ADDR_W+1)-bit binary write counter, drives the RAM write
//   address/strobe, exports a registered Gray write pointer to the read
//   domain, and derives full / free_count / almost_full from the
//   synchronised Gray read pointer. A sticky overflow flag records any push
//   attempted while full.
// Ports:
//   clk_tx                         tx-domain clock
//   rst_tx                         synchronous reset, active-high
//   push                           write request from producer
//   synced_graycoded_read_pointer  Gray read pointer, already in clk_tx
//   clr_overflow                   clears the sticky overflow flag
//   write_en                       push accepted this cycle (RAM write strobe)
//   write_pointer                  RAM write address
//   graycoded_write_pointer        registered Gray write pointer for the CDC
//   full                           FIFO full
//   almost_full                    free slots <= AFULL_TH
//   free_count                     free slots, 0..DEPTH
//   overflow                       sticky: push attempted while full
module async_fifo_wptr_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AFULL_TH = 2
) (
  input  logic              clk_tx,
  input  logic              rst_tx,
  input  logic              push,
  input  logic [ADDR_W:0]   synced_graycoded_read_pointer,
  input  logic              clr_overflow,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_pointer,
  output logic [ADDR_W:0]   graycoded_write_pointer,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   free_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(1) << ADDR_W;
  // The two MSBs of the Gray pointers differ when full; lower bits match.
  // For ADDR_W=1 the mask covers the whole pointer, so the lower field is empty.
  localparam logic [ADDR_W:0] TOP_MASK = (ADDR_W+1)'(3) << (ADDR_W-1);
  localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W+1)'(AFULL_TH);

  logic [ADDR_W:0] write_counter;
  logic [ADDR_W:0] write_gray;
  logic [ADDR_W:0] read_bin;
  logic [ADDR_W:0] used;

  // Gray decode: bit i is the XOR of all Gray bits at and above i.
  for (genvar i = 0; i <= ADDR_W; i++) begin : g_rdec
    assign read_bin[i] = ^(synced_graycoded_read_pointer >> i);
  end

  always_comb begin
    write_gray    = write_counter ^ (write_counter >> 1);
    full          = (write_gray == (synced_graycoded_read_pointer ^ TOP_MASK));
    write_en      = push & ~full;
    write_pointer = write_counter[ADDR_W-1:0];
    used          = write_counter - read_bin;
    free_count    = DEPTH_V - used;
    almost_full   = (free_count <= AFULL_V);
  end

  always_ff @(posedge clk_tx) begin
    if (rst_tx) begin
      write_counter           <= '0;
      graycoded_write_pointer <= '0;
      overflow                <= 1'b0;
    end else begin
      if (write_en) begin
        write_counter <= write_counter + 1'b1;
      end
      graycoded_write_pointer <= write_gray;
      if (push && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
